// File: rtl/ram_loader.sv
// ram_loader: CPU main memory with a sequential byte loader and a check/display port.
module ram_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        cpustate,
    input  logic [15:0]       memaddr,
    input  logic [7:0]        data_out,
    input  logic              read,
    input  logic              write,
    output logic [7:0]        data_in,
    input  logic              ld_valid,
    input  logic [7:0]        ld_data,
    output logic              ld_ready,
    output logic [ADDR_W:0]   ld_cnt,
    output logic              ld_full,
    input  logic              chk_step,
    output logic [ADDR_W-1:0] chk_addr,
    output logic [7:0]        chk_data,
    output logic              addr_err,
    output logic [1:0]        mode
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_LOAD  = 2'b01,
        S_RUN   = 2'b10,
        S_CHECK = 2'b11
    } state_t;

    logic [7:0] mem [DEPTH];

    state_t            state_q,    state_d;
    logic [ADDR_W-1:0] load_ptr_q, load_ptr_d;
    logic [ADDR_W-1:0] chk_addr_q, chk_addr_d;
    logic [CNT_W-1:0]  ld_cnt_q,   ld_cnt_d;
    logic              ld_full_q,  ld_full_d;
    logic              addr_err_q, addr_err_d;
    logic              ld_ready_q, ld_ready_d;

    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_waddr_c;
    logic [7:0]        mem_wdata_c;
    logic [ADDR_W-1:0] cpu_addr_c;
    logic              cpu_hi_c;

    assign cpu_addr_c = memaddr[ADDR_W-1:0];
    assign cpu_hi_c   = (memaddr[15:ADDR_W] != '0);

    // Next-state, pointer updates and memory write selection, judged by the current state
    always_comb begin
        state_d     = state_t'(cpustate);
        load_ptr_d  = load_ptr_q;
        chk_addr_d  = chk_addr_q;
        ld_cnt_d    = ld_cnt_q;
        ld_full_d   = ld_full_q;
        addr_err_d  = addr_err_q;
        mem_we_c    = 1'b0;
        mem_waddr_c = load_ptr_q;
        mem_wdata_c = ld_data;

        case (state_q)
            S_LOAD: begin
                if (ld_valid) begin
                    mem_we_c    = 1'b1;
                    mem_waddr_c = load_ptr_q;
                    mem_wdata_c = ld_data;
                    load_ptr_d  = load_ptr_q + ADDR_W'(1);
                    if (ld_cnt_q < CNT_W'(DEPTH)) begin
                        ld_cnt_d = ld_cnt_q + CNT_W'(1);
                    end
                    if (load_ptr_q == ADDR_W'(DEPTH - 1)) begin
                        ld_full_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (write) begin
                    mem_we_c    = 1'b1;
                    mem_waddr_c = cpu_addr_c;
                    mem_wdata_c = data_out;
                end
                if ((read || write) && cpu_hi_c) begin
                    addr_err_d = 1'b1;
                end
            end
            S_CHECK: begin
                if (chk_step) begin
                    chk_addr_d = chk_addr_q + ADDR_W'(1);
                end
            end
            default: begin
            end
        endcase

        // Entry actions on the edge that changes the state
        if (state_d == S_LOAD && state_q != S_LOAD) begin
            load_ptr_d = '0;
            ld_cnt_d   = '0;
            ld_full_d  = 1'b0;
        end
        if (state_d == S_CHECK && state_q != S_CHECK) begin
            chk_addr_d = '0;
        end

        ld_ready_d = (state_d == S_LOAD);
    end

    // State and control registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            load_ptr_q <= '0;
            chk_addr_q <= '0;
            ld_cnt_q   <= '0;
            ld_full_q  <= 1'b0;
            addr_err_q <= 1'b0;
            ld_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_ptr_q <= load_ptr_d;
            chk_addr_q <= chk_addr_d;
            ld_cnt_q   <= ld_cnt_d;
            ld_full_q  <= ld_full_d;
            addr_err_q <= addr_err_d;
            ld_ready_q <= ld_ready_d;
        end
    end

    // Memory array: contents survive reset, but a write coinciding with reset is dropped
    always_ff @(posedge clk) begin
        if (!rst && mem_we_c) begin
            mem[mem_waddr_c] <= mem_wdata_c;
        end
    end

    assign data_in  = (state_q == S_RUN && read) ? mem[cpu_addr_c] : 8'h00;
    assign chk_data = mem[chk_addr_q];
    assign chk_addr = chk_addr_q;
    assign ld_cnt   = ld_cnt_q;
    assign ld_full  = ld_full_q;
    assign ld_ready = ld_ready_q;
    assign addr_err = addr_err_q;
    assign mode     = state_q;

endmodule

// File: tb/tb_ram_loader.sv
// Directed testbench for ram_loader (ADDR_W = 8, DEPTH = 256).
module tb_ram_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cpustate;
    logic [15:0] memaddr;
    logic [7:0]  data_out;
    logic        read;
    logic        write;
    logic [7:0]  data_in;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic [8:0]  ld_cnt;
    logic        ld_full;
    logic        chk_step;
    logic [7:0]  chk_addr;
    logic [7:0]  chk_data;
    logic        addr_err;
    logic [1:0]  mode;

    int checks   = 0;
    int failures = 0;

    ram_loader #(.ADDR_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .cpustate (cpustate),
        .memaddr  (memaddr),
        .data_out (data_out),
        .read     (read),
        .write    (write),
        .data_in  (data_in),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_ready (ld_ready),
        .ld_cnt   (ld_cnt),
        .ld_full  (ld_full),
        .chk_step (chk_step),
        .chk_addr (chk_addr),
        .chk_data (chk_data),
        .addr_err (addr_err),
        .mode     (mode)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".mode"},     32'(mode),     32'h0);
        check({tag, ".ld_ready"}, 32'(ld_ready), 32'h0);
        check({tag, ".ld_cnt"},   32'(ld_cnt),   32'h0);
        check({tag, ".ld_full"},  32'(ld_full),  32'h0);
        check({tag, ".chk_addr"}, 32'(chk_addr), 32'h0);
        check({tag, ".addr_err"}, 32'(addr_err), 32'h0);
        check({tag, ".data_in"},  32'(data_in),  32'h0);
    endtask

    initial begin
        rst = 1'b1; cpustate = 2'b00; memaddr = 16'h0; data_out = 8'h0;
        read = 1'b0; write = 1'b0; ld_valid = 1'b0; ld_data = 8'h0; chk_step = 1'b0;
        step(); step();
        check_reset_outputs("reset");
        @(negedge clk); rst = 1'b0;

        // Load 11,22,33 from address 0
        cpustate = 2'b01;
        step();
        check("load.mode", 32'(mode), 32'h1);
        check("load.ready", 32'(ld_ready), 32'h1);
        ld_valid = 1'b1;
        ld_data = 8'h11; step();
        ld_data = 8'h22; step();
        ld_data = 8'h33; step();
        ld_valid = 1'b0;
        check("load3.cnt", 32'(ld_cnt), 32'd3);
        check("load3.full", 32'(ld_full), 32'h0);

        // Read them back through the check port
        cpustate = 2'b11;
        step();
        check("chk0.ready", 32'(ld_ready), 32'h0);
        check("chk0.data", 32'(chk_data), 32'h11);
        chk_step = 1'b1;
        step(); check("chk1.data", 32'(chk_data), 32'h22);
        step(); check("chk2.data", 32'(chk_data), 32'h33);
        chk_step = 1'b0;

        // Re-enter LOAD and stream DEPTH+2 bytes to wrap
        cpustate = 2'b01;
        step();
        check("reload.cnt_clear", 32'(ld_cnt), 32'd0);
        ld_valid = 1'b1;
        for (int i = 0; i < 258; i++) begin
            ld_data = 8'(i);
            step();
            if (i == 254) begin
                check("wrap255.cnt", 32'(ld_cnt), 32'd255);
                check("wrap255.full", 32'(ld_full), 32'h0);
            end
        end
        ld_valid = 1'b0;
        check("wrap.cnt", 32'(ld_cnt), 32'd256);
        check("wrap.full", 32'(ld_full), 32'h1);
        cpustate = 2'b11;
        step();
        check("wrap.mem0", 32'(chk_data), 32'h00);
        chk_step = 1'b1; step(); chk_step = 1'b0;
        check("wrap.mem1", 32'(chk_data), 32'h01);

        // Reload 11,22,33; a write strobe in the last LOAD cycle is ignored
        cpustate = 2'b01;
        step();
        ld_valid = 1'b1;
        ld_data = 8'h11; step();
        ld_data = 8'h22; step();
        ld_data = 8'h33;
        cpustate = 2'b10; write = 1'b1; memaddr = 16'h0005; data_out = 8'hEE;
        step();
        ld_valid = 1'b0; write = 1'b0;
        check("run.mode", 32'(mode), 32'h2);
        check("run.cnt_frozen", 32'(ld_cnt), 32'd3);

        // RUN: reads and writes
        read = 1'b1; #1;
        check("run.rd5_old", 32'(data_in), 32'h05);
        write = 1'b1; data_out = 8'hA5; #1;
        check("run.rdwr_same_cycle", 32'(data_in), 32'h05);
        step();
        write = 1'b0; #1;
        check("run.rd5_new", 32'(data_in), 32'hA5);
        read = 1'b0; #1;
        check("run.noread", 32'(data_in), 32'h00);
        read = 1'b1; memaddr = 16'h0105; #1;
        check("run.alias_rd", 32'(data_in), 32'hA5);
        check("run.err_before_edge", 32'(addr_err), 32'h0);
        step();
        check("run.err_set", 32'(addr_err), 32'h1);
        read = 1'b0; write = 1'b1; memaddr = 16'h0207; data_out = 8'h77;
        step();
        write = 1'b0; read = 1'b1; memaddr = 16'h0007; #1;
        check("run.alias_wr", 32'(data_in), 32'h77);
        memaddr = 16'h0003;
        step();
        check("run.rd3", 32'(data_in), 32'h03);
        check("run.err_sticky", 32'(addr_err), 32'h1);

        // CHECK: two steps, then loader and CPU strobes are ignored
        read = 1'b0; cpustate = 2'b11;
        step();
        check("chk.entry_addr", 32'(chk_addr), 32'h0);
        chk_step = 1'b1; step(); step(); chk_step = 1'b0;
        check("chk.addr2", 32'(chk_addr), 32'h2);
        check("chk.data2", 32'(chk_data), 32'h33);
        ld_valid = 1'b1; ld_data = 8'hFF; write = 1'b1; read = 1'b1; memaddr = 16'h0002; data_out = 8'hFF;
        step();
        check("chk.ignore_data", 32'(chk_data), 32'h33);
        check("chk.data_in_zero", 32'(data_in), 32'h00);
        ld_valid = 1'b0; write = 1'b0; read = 1'b0;
        chk_step = 1'b1;
        for (int i = 0; i < 254; i++) step();
        chk_step = 1'b0;
        check("chk.wrap_addr", 32'(chk_addr), 32'h0);
        check("chk.wrap_data", 32'(chk_data), 32'h11);
        check("chk.err_kept", 32'(addr_err), 32'h1);

        // Reset in the middle of a load stream
        cpustate = 2'b01;
        step();
        ld_valid = 1'b1;
        ld_data = 8'h11; step();
        ld_data = 8'h22; step();
        ld_data = 8'h33; step();
        ld_data = 8'h44; step();
        ld_data = 8'h55;
        @(negedge clk); rst = 1'b1; #1;
        check_reset_outputs("midrst");
        step();
        @(negedge clk); rst = 1'b0; ld_valid = 1'b0; cpustate = 2'b11;
        step();
        check("post.mode", 32'(mode), 32'h3);
        check("post.mem0", 32'(chk_data), 32'h11);
        chk_step = 1'b1;
        step(); check("post.mem1", 32'(chk_data), 32'h22);
        step(); check("post.mem2", 32'(chk_data), 32'h33);
        step(); check("post.mem3", 32'(chk_data), 32'h44);
        step(); check("post.mem4_dropped", 32'(chk_data), 32'h04);
        chk_step = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
